i_cache_set_assoc: RTL



---
 rtl/i_cache_pkg.sv | 32 +++
 rtl/i_cache_way.sv | 60 ++++++
 rtl/i_cache_set_assoc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared definitions for the two-way set-associative I-cache.
//   state_e         refill FSM states (IDLE / REQ / WAIT)
//   tag_width()     tag bits left after index and byte offset
//   words_per_line  32-bit words held by one cache line
//   refill_addr()   word address of refill beat 'word' within a line
package i_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic int tag_width(input int index_w, input int offset_w);
    return 32 - index_w - offset_w;
  endfunction

  function automatic int words_per_line(input int offset_w);
    return 1 << (offset_w - 2);
  endfunction

  // line_addr carries tag and index; its offset bits are replaced by the
  // beat number shifted to a word boundary.
  function automatic logic [31:0] refill_addr(input logic [31:0] line_addr,
                                              input logic [31:0] word,
                                              input int          offset_w);
    logic [31:0] mask;
    mask = (32'd1 << offset_w) - 32'd1;
    return (line_addr & ~mask) | ((word << 2) & mask);
  endfunction

endpackage

// File: rtl/i_cache_way.sv
// i_cache_way: storage for one way of the I-cache (valid, tag, line data).
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid bits)
//   inv             clear every valid bit at the next edge
//   rd_index/word   combinational lookup -> rd_valid, rd_tag, rd_data
//   wr_en           write wr_data into word wr_word of set wr_index
//   fill_en         finish a fill of set wr_index: store fill_tag and
//                   set the valid bit to fill_valid
module i_cache_way
  import i_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          inv,
  input  logic [INDEX_WIDTH-1:0]                        rd_index,
  input  logic [OFFSET_WIDTH-3:0]                       rd_word,
  output logic                                          rd_valid,
  output logic [tag_width(INDEX_WIDTH, OFFSET_WIDTH)-1:0] rd_tag,
  output logic [31:0]                                   rd_data,
  input  logic                                          wr_en,
  input  logic [INDEX_WIDTH-1:0]                        wr_index,
  input  logic [OFFSET_WIDTH-3:0]                       wr_word,
  input  logic [31:0]                                   wr_data,
  input  logic                                          fill_en,
  input  logic [tag_width(INDEX_WIDTH, OFFSET_WIDTH)-1:0] fill_tag,
  input  logic                                          fill_valid
);

  localparam int TAG_WIDTH = tag_width(INDEX_WIDTH, OFFSET_WIDTH);
  localparam int WORDS     = words_per_line(OFFSET_WIDTH);
  localparam int SETS      = 1 << INDEX_WIDTH;

  logic [SETS-1:0]      valid;
  logic [TAG_WIDTH-1:0] tags [SETS];
  logic [31:0]          data [SETS*WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (inv)     valid           <= '0;
      // A fill that lands together with inv writes fill_valid = 0, so the
      // later assignment never resurrects an invalidated line.
      if (fill_en) valid[wr_index] <= fill_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)   data[{wr_index, wr_word}] <= wr_data;
    if (fill_en) tags[wr_index]            <= fill_tag;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[{rd_index, rd_word}];

endmodule

// File: rtl/i_cache_set_assoc.sv
// i_cache_set_assoc: two-way set-associative, multi-word-line, read-only
// instruction cache between the core fetch port and the sram-like bridge.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_inst_*                    core fetch port; hits answer with
//                                 addr_ok = data_ok = 1 in the same cycle
//   cache_inv                     invalidate every line (safe mid-refill)
//   cache_inst_*                  refill port, one word per transaction
module i_cache_set_assoc
  import i_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  input  logic        cache_inv,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int TAG_WIDTH = tag_width(INDEX_WIDTH, OFFSET_WIDTH);
  localparam int WORDS     = words_per_line(OFFSET_WIDTH);
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int WORD_BITS = OFFSET_WIDTH - 2;

  state_e state, next;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [WORD_BITS-1:0]   req_word;

  logic [TAG_WIDTH-1:0]   tag_l;
  logic [INDEX_WIDTH-1:0] index_l;
  logic [WORD_BITS-1:0]   cnt;
  logic                   victim;
  logic                   inv_pend;
  logic [SETS-1:0]        lru;

  logic                   valid0, valid1;
  logic [TAG_WIDTH-1:0]   tag0, tag1;
  logic [31:0]            data0, data1;

  logic hit0, hit1, lookup, hit, miss;
  logic fill_word, fill_last, fill_valid, pick;
  logic unused_ok;

  assign req_tag   = cpu_inst_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign req_index = cpu_inst_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign req_word  = cpu_inst_addr[OFFSET_WIDTH-1:2];

  // Write-side and size inputs have no meaning for a read-only cache.
  assign unused_ok = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  assign hit0   = valid0 && (tag0 == req_tag);
  assign hit1   = valid1 && (tag1 == req_tag);
  assign lookup = (state == IDLE) && cpu_inst_req;
  assign hit    = lookup && (hit0 || hit1);
  assign miss   = lookup && !(hit0 || hit1);

  // A beat lands either in WAIT, or in REQ when the bridge returns the
  // data in the same cycle it accepts the address.
  assign fill_word  = ((state == WAIT) && cache_inst_data_ok) ||
                      ((state == REQ) && cache_inst_addr_ok && cache_inst_data_ok);
  assign fill_last  = fill_word && (cnt == WORD_BITS'(WORDS - 1));
  // An invalidate seen at any point of the refill, including its last
  // beat, leaves the freshly filled line invalid.
  assign fill_valid = !(inv_pend || cache_inv);

  // Victim choice: free way0, then free way1, then the LRU way.
  assign pick = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[req_index]);

  i_cache_way #(.INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) u_way0 (
    .clk        (clk),
    .rst        (rst),
    .inv        (cache_inv),
    .rd_index   (req_index),
    .rd_word    (req_word),
    .rd_valid   (valid0),
    .rd_tag     (tag0),
    .rd_data    (data0),
    .wr_en      (fill_word && !victim),
    .wr_index   (index_l),
    .wr_word    (cnt),
    .wr_data    (cache_inst_rdata),
    .fill_en    (fill_last && !victim),
    .fill_tag   (tag_l),
    .fill_valid (fill_valid)
  );

  i_cache_way #(.INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) u_way1 (
    .clk        (clk),
    .rst        (rst),
    .inv        (cache_inv),
    .rd_index   (req_index),
    .rd_word    (req_word),
    .rd_valid   (valid1),
    .rd_tag     (tag1),
    .rd_data    (data1),
    .wr_en      (fill_word && victim),
    .wr_index   (index_l),
    .wr_word    (cnt),
    .wr_data    (cache_inst_rdata),
    .fill_en    (fill_last && victim),
    .fill_tag   (tag_l),
    .fill_valid (fill_valid)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE: if (miss) next = REQ;
      REQ: begin
        if (cache_inst_addr_ok) begin
          if (cache_inst_data_ok) next = fill_last ? IDLE : REQ;
          else                    next = WAIT;
        end
      end
      WAIT: if (cache_inst_data_ok) next = fill_last ? IDLE : REQ;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      victim   <= 1'b0;
      inv_pend <= 1'b0;
      lru      <= '0;
    end else begin
      state <= next;

      if (miss) begin
        cnt    <= '0;
        victim <= pick;
      end else if (fill_last) begin
        cnt <= '0;
      end else if (fill_word) begin
        cnt <= cnt + 1'b1;
      end

      if ((state != IDLE) && (next == IDLE)) inv_pend <= 1'b0;
      else if (cache_inv && (state != IDLE)) inv_pend <= 1'b1;

      // lru names the way to evict next, so it points away from the way
      // just used.
      if (hit)            lru[req_index] <= hit0;
      else if (fill_last) lru[index_l]   <= ~victim;
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      tag_l   <= req_tag;
      index_l <= req_index;
    end
  end

  assign cpu_inst_addr_ok = hit;
  assign cpu_inst_data_ok = hit;
  assign cpu_inst_rdata   = hit ? (hit0 ? data0 : data1) : 32'd0;

  assign cache_inst_req   = (state == REQ);
  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = 32'd0;
  assign cache_inst_addr  = refill_addr({tag_l, index_l, {OFFSET_WIDTH{1'b0}}},
                                        32'(cnt), OFFSET_WIDTH);

endmodule
